// File: rtl/mouse_position_tracker.sv
// Integrates PS/2 mouse packet deltas into a clamped absolute X/Y cursor and exposes it as bus registers.
// Define MOUSE_TRACKER_Y_INVERT_EN to negate the Y delta (top-left screen origin).
module mouse_position_tracker #(
  parameter int unsigned MOUSE_LIMIT_X = 160,
  parameter int unsigned MOUSE_LIMIT_Y = 120,
  parameter logic [7:0]  BASE_ADDR     = 8'hA0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic       SEND_INTERRUPT,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OUT_EN,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [1:0] MOUSE_BUTTONS
);

  localparam int unsigned PW   = 8;
  localparam int unsigned SW   = PW + 2;
  localparam int unsigned NREG = 3;
`ifdef MOUSE_TRACKER_Y_INVERT_EN
  localparam bit Y_INVERT = 1'b1;
`else
  localparam bit Y_INVERT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic [3:0]      pend_status_q, pend_status_d;
  logic [PW-1:0]   pend_dx_q, pend_dx_d;
  logic [PW-1:0]   pend_dy_q, pend_dy_d;
  logic [3:0]      work_status_q, work_status_d;
  logic [PW-1:0]   work_dx_q, work_dx_d;
  logic [PW-1:0]   work_dy_q, work_dy_d;
  logic [PW-1:0]   shadow_x_q, shadow_x_d;
  logic [PW-1:0]   shadow_y_q, shadow_y_d;
  logic [PW-1:0]   mouse_x_q, mouse_x_d;
  logic [PW-1:0]   mouse_y_q, mouse_y_d;
  logic [1:0]      mouse_btn_q, mouse_btn_d;
  logic            raise_q, raise_d;
  logic [PW-1:0]   bus_data_q, bus_data_d;
  logic            bus_en_q, bus_en_d;

  logic                 calc_y;
  logic [PW-1:0]        cur_pos;
  logic [PW-1:0]        delta_mag;
  logic                 delta_sign;
  logic signed [SW-1:0] cur_s;
  logic signed [SW-1:0] delta_s;
  logic signed [SW-1:0] sum_s;
  logic signed [SW-1:0] limit_m1_s;
  logic [PW-1:0]        clamped;
  logic [PW-1:0]        bus_offset;

  // Shared add-and-clamp datapath, steered to X in CALC_X and Y in CALC_Y
  always_comb begin
    calc_y     = (state_q == CALC_Y);
    cur_pos    = calc_y ? mouse_y_q : mouse_x_q;
    delta_mag  = calc_y ? work_dy_q : work_dx_q;
    delta_sign = calc_y ? work_status_q[0] : work_status_q[1];
    limit_m1_s = calc_y ? SW'(MOUSE_LIMIT_Y - 1) : SW'(MOUSE_LIMIT_X - 1);
    cur_s      = {2'b00, cur_pos};
    delta_s    = {delta_sign, delta_sign, delta_mag};
    if (Y_INVERT && calc_y) begin
      sum_s = cur_s - delta_s;
    end else begin
      sum_s = cur_s + delta_s;
    end
    if (sum_s[SW-1]) begin
      clamped = '0;
    end else if (sum_s > limit_m1_s) begin
      clamped = limit_m1_s[PW-1:0];
    end else begin
      clamped = sum_s[PW-1:0];
    end
  end

  // Next-state, capture buffer, commit, interrupt and bus read logic
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_status_d = pend_status_q;
    pend_dx_d     = pend_dx_q;
    pend_dy_d     = pend_dy_q;
    work_status_d = work_status_q;
    work_dx_d     = work_dx_q;
    work_dy_d     = work_dy_q;
    shadow_x_d    = shadow_x_q;
    shadow_y_d    = shadow_y_q;
    mouse_x_d     = mouse_x_q;
    mouse_y_d     = mouse_y_q;
    mouse_btn_d   = mouse_btn_q;
    raise_d       = raise_q;
    bus_offset    = BUS_ADDR - BASE_ADDR;
    bus_en_d      = 1'b0;
    bus_data_d    = '0;

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          state_d       = CALC_X;
          work_status_d = pend_status_q;
          work_dx_d     = pend_dx_q;
          work_dy_d     = pend_dy_q;
          pend_valid_d  = 1'b0;
        end
      end
      CALC_X: begin
        shadow_x_d = clamped;
        state_d    = CALC_Y;
      end
      CALC_Y: begin
        shadow_y_d = clamped;
        state_d    = COMMIT;
      end
      COMMIT: begin
        mouse_x_d   = shadow_x_q;
        mouse_y_d   = shadow_y_q;
        mouse_btn_d = work_status_q[3:2];
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pulse arriving as the buffer drains re-fills it; newest packet wins
    if (SEND_INTERRUPT) begin
      pend_valid_d  = 1'b1;
      pend_status_d = MOUSE_STATUS;
      pend_dx_d     = MOUSE_DX;
      pend_dy_d     = MOUSE_DY;
    end

    if (state_q == COMMIT) begin
      raise_d = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_d = 1'b0;
    end

    if (!BUS_WE && (bus_offset < PW'(NREG))) begin
      bus_en_d = 1'b1;
      case (bus_offset)
        8'd0:    bus_data_d = {6'b0, mouse_btn_q};
        8'd1:    bus_data_d = mouse_x_q;
        default: bus_data_d = mouse_y_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      pend_valid_q  <= 1'b0;
      pend_status_q <= '0;
      pend_dx_q     <= '0;
      pend_dy_q     <= '0;
      work_status_q <= '0;
      work_dx_q     <= '0;
      work_dy_q     <= '0;
      shadow_x_q    <= '0;
      shadow_y_q    <= '0;
      mouse_x_q     <= PW'(MOUSE_LIMIT_X / 2);
      mouse_y_q     <= PW'(MOUSE_LIMIT_Y / 2);
      mouse_btn_q   <= '0;
      raise_q       <= 1'b0;
      bus_data_q    <= '0;
      bus_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_status_q <= pend_status_d;
      pend_dx_q     <= pend_dx_d;
      pend_dy_q     <= pend_dy_d;
      work_status_q <= work_status_d;
      work_dx_q     <= work_dx_d;
      work_dy_q     <= work_dy_d;
      shadow_x_q    <= shadow_x_d;
      shadow_y_q    <= shadow_y_d;
      mouse_x_q     <= mouse_x_d;
      mouse_y_q     <= mouse_y_d;
      mouse_btn_q   <= mouse_btn_d;
      raise_q       <= raise_d;
      bus_data_q    <= bus_data_d;
      bus_en_q      <= bus_en_d;
    end
  end

  assign MOUSE_X             = mouse_x_q;
  assign MOUSE_Y             = mouse_y_q;
  assign MOUSE_BUTTONS       = mouse_btn_q;
  assign BUS_INTERRUPT_RAISE = raise_q;
  assign BUS_DATA_OUT        = bus_data_q;
  assign BUS_DATA_OUT_EN     = bus_en_q;

endmodule

// File: doc/mouse_position_tracker.md
Name: mouse_position_tracker

Overview:
- Sits directly downstream of the PS/2 mouse transceiver.
- Consumes each decoded packet (status, DX, DY, packet-valid pulse) and integrates the signed deltas into an absolute X/Y cursor position, clamped to a screen window.
- Exposes button/position registers to the microprocessor bus as read-only memory-mapped registers, and raises a bus interrupt on every committed update.

Parameters:
- MOUSE_LIMIT_X, 160: X range; position is held in 0..MOUSE_LIMIT_X-1.
- MOUSE_LIMIT_Y, 120: Y range; position is held in 0..MOUSE_LIMIT_Y-1.
- BASE_ADDR, 8'hA0: bus base address of the 3-register window.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- MOUSE_STATUS  in  4  {L, R, X_sign, Y_sign}
- MOUSE_DX  in  8  X delta magnitude bits; sign is MOUSE_STATUS[1]
- MOUSE_DY  in  8  Y delta magnitude bits; sign is MOUSE_STATUS[0]
- SEND_INTERRUPT  in  1  one-cycle pulse; packet inputs valid this cycle
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  bus write strobe; writes are ignored
- BUS_DATA_OUT  out  8  read data
- BUS_DATA_OUT_EN  out  1  high when BUS_DATA_OUT is driven
- BUS_INTERRUPT_RAISE  out  1  level interrupt request to the processor
- BUS_INTERRUPT_ACK  in  1  one-cycle acknowledge from the processor
- MOUSE_X  out  8  current X position
- MOUSE_Y  out  8  current Y position
- MOUSE_BUTTONS  out  2  {L, R} as of the last commit

Behaviour:
- Reset values: MOUSE_X = MOUSE_LIMIT_X/2 (80), MOUSE_Y = MOUSE_LIMIT_Y/2 (60), MOUSE_BUTTONS = 0, BUS_INTERRUPT_RAISE = 0, BUS_DATA_OUT = 0, BUS_DATA_OUT_EN = 0, FSM in IDLE, pending buffer empty.
- Capture:
  - On SEND_INTERRUPT, register status/DX/DY into a 1-entry pending buffer and set pending-valid.
  - If pending-valid is already set, overwrite it (newest packet wins).
- FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
  - IDLE -> CALC_X when pending-valid is set. Entering CALC_X moves the buffer into a working register and clears pending-valid in the same cycle; a new pulse in that same cycle sets pending-valid again.
  - CALC_X: dx9 = {X_sign, DX} as 9-bit two's complement; sum = X + dx9 as 10-bit signed. If sum < 0 then 0; if sum > LIMIT_X-1 then LIMIT_X-1; else sum. Result goes to a shadow register.
  - CALC_Y: same computation for Y with Y_sign/DY and LIMIT_Y.
  - COMMIT: MOUSE_X, MOUSE_Y and MOUSE_BUTTONS update together; BUS_INTERRUPT_RAISE is set to 1. Next state is IDLE.
- Latency: pulse at cycle N gives the capture at N; MOUSE_X/Y are visible at N+4 when the FSM starts from IDLE.
- Outputs never show a partially updated X/Y pair.
- Interrupt:
  - BUS_INTERRUPT_ACK clears RAISE on the next edge.
  - If COMMIT and ACK fall in the same cycle, RAISE ends at 1 (set wins).
  - ACK while RAISE = 0 has no effect.
- Bus reads: when BUS_WE = 0 and BUS_ADDR is in the window, the next cycle drives BUS_DATA_OUT_EN = 1 with:
  - BASE+0 = {6'b0, L, R}
  - BASE+1 = MOUSE_X
  - BASE+2 = MOUSE_Y
- For any other address, or when BUS_WE = 1, the next cycle has EN = 0 and DATA = 0.
- Reset mid-operation: FSM returns to IDLE, the pending packet and the in-flight computation are discarded, and all outputs take their reset values.

Optional Feature:
- Macro: MOUSE_TRACKER_Y_INVERT_EN.
- Defined: the Y delta is negated before accumulation (sum = Y - dy9), so screen origin is top-left and mouse "up" decreases Y. Clamping is unchanged.
- Undefined: sum = Y + dy9 as specified above.

Test Plan:
- Reset, then read BASE+1 and BASE+2 -> 80 and 60; RAISE = 0; BUS_DATA_OUT_EN high exactly one cycle after each read.
- Packet status = 4'b1000, DX = 10, DY = 5 -> four cycles later X = 90, Y = 65 (Y = 55 with the macro defined), BUTTONS = 2'b10, RAISE = 1; ACK -> RAISE = 0 on the next cycle.
- Packet X_sign = 1, DX = 8'h00 (-256) -> X = 0. Then DX = 8'h7F repeated twice -> X = 159, clamped, no wrap. Same check for Y, bounded at 119.
- Two SEND_INTERRUPT pulses 1 cycle apart, then a third 2 cycles later while the FSM is busy -> exactly two commits; the second commit uses the third packet's deltas; no X/Y tearing.
- ACK asserted in the same cycle as COMMIT -> RAISE remains 1. Read with BUS_WE = 1 at BASE+1 -> EN stays 0.
- Assert RESET during CALC_Y after a packet DX = 20 -> X = 80, Y = 60, RAISE = 0; no commit occurs afterwards.
